array_refresh_sched: RTL and testbench

Periodic refresh scheduler sitting directly upstream of `array_refresh`. It counts the refresh interval `array_tREFI`, accumulates owed refreshes, and requests a refresh slot from the access arbiter. Once the slot is granted, it issues a one-cycle `array_rf_start` to `array_refresh` and holds the slot until `array_rf_done` returns. It raises an urgency flag when the backlog grows and a sticky overflow flag if owed refreshes are lost.

---
 rtl/array_refresh_sched.sv | 98 +++++++++
 tb/tb_array_refresh_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/array_refresh_sched.sv
// Periodic refresh scheduler: counts tREFI, keeps the owed-refresh backlog and
// hands refresh slots from the access arbiter to array_refresh.
module array_refresh_sched #(
    parameter int PEND_WIDTH = 4,
    parameter int MAX_PEND   = 8,
    parameter int URGENT_TH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sched_en,
    input  logic [15:0]           array_tREFI,
    output logic                  rf_req,
    input  logic                  rf_gnt,
    output logic                  rf_busy,
    output logic                  array_rf_start,
    input  logic                  array_rf_done,
    output logic [PEND_WIDTH-1:0] pend_cnt,
    output logic                  rf_urgent,
    output logic                  rf_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_START, S_WAIT} state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = PEND_WIDTH'(MAX_PEND);
    localparam logic [PEND_WIDTH-1:0] PEND_URG = PEND_WIDTH'(URGENT_TH);

    state_t                state_q, state_d;
    logic [15:0]           ref_cnt_q, ref_cnt_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    logic                  tick;
    logic                  done_acc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    // The >= compare lets a lowered interval tick at once instead of wrapping 64k cycles.
    always_comb begin
        tick      = 1'b0;
        ref_cnt_d = ref_cnt_q;
        if (!sched_en || array_tREFI == 16'd0) begin
            ref_cnt_d = 16'd0;
        end else if (ref_cnt_q >= array_tREFI - 16'd1) begin
            tick      = 1'b1;
            ref_cnt_d = 16'd0;
        end else begin
            ref_cnt_d = ref_cnt_q + 16'd1;
        end
    end

    assign done_acc = (state_q == S_WAIT) && array_rf_done;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !done_acc) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (done_acc && !tick && pend_q != '0) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pend_q != '0) state_d = S_REQ;
            S_REQ:   if (rf_gnt) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (array_rf_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ref_cnt_q <= 16'd0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rf_req         = (state_q == S_REQ);
    assign array_rf_start = (state_q == S_START);
    assign rf_busy        = (state_q == S_START) || (state_q == S_WAIT);
    assign pend_cnt       = pend_q;
    assign rf_urgent      = (pend_q >= PEND_URG);
    assign rf_overflow    = ovf_q;

endmodule

// File: tb/tb_array_refresh_sched.sv
// Bench for array_refresh_sched: directed timing checks plus a per-cycle
// scoreboard fed by a behavioural model of the scheduler.
module tb_array_refresh_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sched_en = 1'b0;
    logic [15:0] array_tREFI = 16'd0;
    logic        rf_req;
    logic        rf_gnt = 1'b0;
    logic        rf_busy;
    logic        array_rf_start;
    logic        array_rf_done = 1'b0;
    logic [3:0]  pend_cnt;
    logic        rf_urgent;
    logic        rf_overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    array_refresh_sched dut (
        .clk            (clk),
        .rst            (rst),
        .sched_en       (sched_en),
        .array_tREFI    (array_tREFI),
        .rf_req         (rf_req),
        .rf_gnt         (rf_gnt),
        .rf_busy        (rf_busy),
        .array_rf_start (array_rf_start),
        .array_rf_done  (array_rf_done),
        .pend_cnt       (pend_cnt),
        .rf_urgent      (rf_urgent),
        .rf_overflow    (rf_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] outs();
        return {rf_req, rf_busy, array_rf_start, rf_urgent, rf_overflow, pend_cnt};
    endfunction

    // Behavioural model: one call per rising edge, pushes the expected outputs.
    typedef enum int {M_IDLE, M_REQ, M_START, M_WAIT} m_state_t;
    m_state_t   m_st = M_IDLE;
    int         m_cnt = 0;
    int         m_pend = 0;
    bit         m_ovf = 1'b0;
    logic [8:0] exp_q[$];

    task automatic model_step();
        bit t;
        bit dacc;
        m_state_t nxt;
        if (rst) begin
            m_st = M_IDLE; m_cnt = 0; m_pend = 0; m_ovf = 1'b0;
        end else begin
            t = 1'b0;
            if (!sched_en || array_tREFI == 0) m_cnt = 0;
            else if (m_cnt + 1 >= int'(array_tREFI)) begin t = 1'b1; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
            dacc = (m_st == M_WAIT) && array_rf_done;
            nxt = m_st;
            case (m_st)
                M_IDLE:  if (m_pend != 0) nxt = M_REQ;
                M_REQ:   if (rf_gnt) nxt = M_START;
                M_START: nxt = M_WAIT;
                M_WAIT:  if (array_rf_done) nxt = M_IDLE;
                default: nxt = M_IDLE;
            endcase
            if (t && !dacc) begin
                if (m_pend == 8) m_ovf = 1'b1;
                else m_pend = m_pend + 1;
            end else if (dacc && !t && m_pend > 0) begin
                m_pend = m_pend - 1;
            end
            m_st = nxt;
        end
        exp_q.push_back({m_st == M_REQ, m_st == M_START || m_st == M_WAIT, m_st == M_START,
                         m_pend >= 6, m_ovf, 4'(m_pend)});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic [8:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard {req,busy,start,urg,ovf,pend}", outs(), e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; sched_en = 1'b0; array_tREFI = 16'd0; rf_gnt = 1'b0; array_rf_done = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
        check("reset_outputs", outs(), 9'd0);
    endtask

    // Acts as array_refresh: answers each start with done `delay` cycles later.
    task automatic drain(input int delay, input int cycles, output int starts);
        int cd;
        cd = -1;
        starts = 0;
        rf_gnt = 1'b1;
        repeat (cycles) begin
            step();
            array_rf_done = 1'b0;
            if (cd > 0) cd--;
            if (array_rf_start) begin starts++; cd = delay; end
            if (cd == 0) begin array_rf_done = 1'b1; cd = -1; end
        end
        rf_gnt = 1'b0;
        array_rf_done = 1'b0;
    endtask

    initial begin
        int starts;
        int ticks;

        // Basic cycle
        do_reset();
        sched_en = 1'b1; array_tREFI = 16'd16; rf_gnt = 1'b1;
        run_to(14); check("basic_no_tick_14", dut.tick, 1'b0);
        run_to(15); check("basic_tick_15", dut.tick, 1'b1);
        run_to(16); check("basic_pend_16", pend_cnt, 4'd1);
                    check("basic_req_low_16", rf_req, 1'b0);
        run_to(17); check("basic_req_17", rf_req, 1'b1);
        run_to(18); check("basic_start_18", {array_rf_start, rf_busy, rf_req}, 3'b110);
        run_to(19); check("basic_start_pulse_19", {array_rf_start, rf_busy}, 2'b01);
        run_to(20); sched_en = 1'b0;
        run_to(38); check("basic_busy_38", rf_busy, 1'b1);
                    array_rf_done = 1'b1;
        run_to(39); array_rf_done = 1'b0;
                    check("basic_done_39", {rf_busy, pend_cnt}, 5'd0);
        run_to(41); check("basic_idle_41", rf_req, 1'b0);

        // Backlog, urgency and simultaneous tick/done at saturation
        do_reset();
        sched_en = 1'b1; array_tREFI = 16'd4; rf_gnt = 1'b0;
        run_to(20); check("backlog_pend5", {rf_urgent, pend_cnt}, {1'b0, 4'd5});
        run_to(24); check("backlog_pend6_urgent", {rf_urgent, pend_cnt}, {1'b1, 4'd6});
        run_to(28); check("backlog_pend7", {rf_urgent, rf_overflow, pend_cnt}, {2'b10, 4'd7});
        run_to(30); rf_gnt = 1'b1;
        run_to(31); check("backlog_start", {array_rf_start, rf_req}, 2'b10);
                    rf_gnt = 1'b0;
        run_to(32); check("sat_pend8_wait", {rf_busy, rf_overflow, pend_cnt}, {2'b10, 4'd8});
        run_to(35); check("simul_tick_35", dut.tick, 1'b1);
                    array_rf_done = 1'b1;
        run_to(36); array_rf_done = 1'b0; sched_en = 1'b0;
                    check("simul_pend_kept", {rf_busy, rf_overflow, pend_cnt}, {2'b00, 4'd8});
        drain(2, 60, starts);
        check("backlog_starts", starts, 8);
        check("backlog_drained", {rf_urgent, rf_overflow, pend_cnt}, 6'd0);

        // Overflow
        do_reset();
        sched_en = 1'b1; array_tREFI = 16'd2;
        run_to(16); check("ovf_pend8", {rf_overflow, pend_cnt}, {1'b0, 4'd8});
        run_to(17); check("ovf_not_yet", rf_overflow, 1'b0);
        run_to(18); check("ovf_set", {rf_overflow, pend_cnt}, {1'b1, 4'd8});
        run_to(30); sched_en = 1'b0;
        drain(1, 60, starts);
        check("ovf_starts", starts, 8);
        check("ovf_sticky_after_drain", {rf_overflow, pend_cnt}, {1'b1, 4'd0});
        do_reset();
        check("ovf_cleared_by_rst", rf_overflow, 1'b0);

        // Spurious inputs
        array_rf_done = 1'b1;
        run_to(1); array_rf_done = 1'b0; rf_gnt = 1'b1;
        run_to(2); rf_gnt = 1'b0;
        run_to(3); check("spur_idle", outs(), 9'd0);
                   sched_en = 1'b1; array_tREFI = 16'd4;
        run_to(9); check("spur_req", {rf_req, pend_cnt}, {1'b1, 4'd1});
                   array_rf_done = 1'b1;
        run_to(10); array_rf_done = 1'b0; sched_en = 1'b0;
                    check("spur_done_in_req", {rf_req, rf_busy, pend_cnt}, {2'b10, 4'd1});

        // tREFI = 0 never ticks
        do_reset();
        sched_en = 1'b1; array_tREFI = 16'd0;
        ticks = 0;
        repeat (100) begin step(); ticks += int'(dut.tick); end
        check("zero_interval_ticks", ticks, 0);
        check("zero_interval_state", {dut.ref_cnt_q, pend_cnt, rf_req}, 21'd0);

        // Lowering the interval mid-count ticks at once
        do_reset();
        sched_en = 1'b1; array_tREFI = 16'd100;
        run_to(49); check("lower_no_tick_49", dut.tick, 1'b0);
        run_to(50); check("lower_ref_cnt_50", dut.ref_cnt_q, 16'd50);
                    array_tREFI = 16'd10;
                    #1;
                    check("lower_tick_50", dut.tick, 1'b1);
        run_to(51); check("lower_pend_51", {dut.ref_cnt_q, pend_cnt}, {16'd0, 4'd1});

        // Reset mid-refresh
        do_reset();
        sched_en = 1'b1; array_tREFI = 16'd4;
        run_to(12); check("midrst_pend3", pend_cnt, 4'd3);
                    rf_gnt = 1'b1;
        run_to(13); rf_gnt = 1'b0;
        run_to(14); check("midrst_wait", {rf_busy, pend_cnt}, {1'b1, 4'd3});
                    rst = 1'b1;
        run_to(15); check("midrst_outputs", outs(), 9'd0);
                    rst = 1'b0; sched_en = 1'b0;
        run_to(16); array_rf_done = 1'b1;
        run_to(17); array_rf_done = 1'b0;
                    check("midrst_late_done", outs(), 9'd0);

        // Random traffic, checked by the scoreboard
        do_reset();
        repeat (400) begin
            step();
            sched_en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) array_tREFI = 16'($urandom_range(0, 6));
            rf_gnt        = ($urandom_range(0, 2) == 0);
            array_rf_done = ($urandom_range(0, 3) == 0);
        end
        sched_en = 1'b0; rf_gnt = 1'b0; array_rf_done = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
